branch_predictor: RTL and testbench

IF-stage branch target buffer with 2-bit saturating direction counters. Each cycle it looks up the fetch PC and supplies `IF_hit` and a predicted next PC to the PC mux. `IF_hit` travels down the pipeline as `ID_EX_hit`. The block is trained in EX from the branch resolution outputs: `PCSrc` and `PC_Branch` for the resolving instruction at `ID_EX_PC`.

---
 rtl/branch_predictor.sv | 142 ++++++++++++++
 tb/tb_branch_predictor.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional performance counters are enabled by defining BP_PERF_CNT_EN.
module branch_predictor #(
  parameter int INDEX_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IF_PC,
  output logic        IF_hit,
  output logic [31:0] IF_pred_PC,
  input  logic [31:0] ID_EX_PC,
  input  logic        ID_EX_Branch,
  input  logic        ID_EX_Jump,
  input  logic        ID_EX_hit,
  input  logic        PCSrc,
  input  logic [31:0] PC_Branch,
  output logic        EX_mispredict
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0] bp_branch_cnt,
  output logic [31:0] bp_mispredict_cnt
`endif
);

  localparam int DEPTH = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  logic             valid_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem    [DEPTH];
  logic [31:0]      target_mem [DEPTH];
  logic [1:0]       ctr_mem    [DEPTH];

  logic [INDEX_W-1:0] look_idx;
  logic [TAG_W-1:0]   look_tag;
  logic [INDEX_W-1:0] upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  logic               upd;
  logic               upd_match;
  logic               wr_en;
  logic               wr_valid;
  logic [TAG_W-1:0]   wr_tag;
  logic [31:0]        wr_target;
  logic [1:0]         wr_ctr;
  logic               unused_pc_bits;

  assign look_idx       = IF_PC[INDEX_W+1:2];
  assign look_tag       = IF_PC[31:INDEX_W+2];
  assign upd_idx        = ID_EX_PC[INDEX_W+1:2];
  assign upd_tag        = ID_EX_PC[31:INDEX_W+2];
  assign upd            = ID_EX_Branch | ID_EX_Jump;
  assign upd_match      = valid_mem[upd_idx] && (tag_mem[upd_idx] == upd_tag);
  assign unused_pc_bits = ^{IF_PC[1:0], ID_EX_PC[1:0]};

  // Lookup: pre-update table contents, no write-through bypass
  always_comb begin
    IF_hit     = 1'b0;
    IF_pred_PC = IF_PC + 32'd4;
    if (valid_mem[look_idx] && (tag_mem[look_idx] == look_tag) && ctr_mem[look_idx][1]) begin
      IF_hit     = 1'b1;
      IF_pred_PC = target_mem[look_idx];
    end else begin
      IF_hit     = 1'b0;
    end
  end

  // Misprediction: wrong direction, or taken with a stale stored target
  always_comb begin
    EX_mispredict = 1'b0;
    if (upd) begin
      EX_mispredict = (ID_EX_hit != PCSrc) ||
                      (ID_EX_hit && PCSrc && (target_mem[upd_idx] != PC_Branch));
    end else begin
      EX_mispredict = 1'b0;
    end
  end

  // Training: compute the single entry written at index(ID_EX_PC)
  always_comb begin
    wr_en     = 1'b0;
    wr_valid  = 1'b1;
    wr_tag    = upd_tag;
    wr_target = PC_Branch;
    wr_ctr    = ctr_mem[upd_idx];
    if (ID_EX_Jump) begin
      wr_en  = 1'b1;
      wr_ctr = 2'b11;
    end else if (ID_EX_Branch) begin
      if (PCSrc) begin
        wr_en = 1'b1;
        if (upd_match) begin
          wr_ctr = (ctr_mem[upd_idx] == 2'b11) ? 2'b11 : ctr_mem[upd_idx] + 2'b01;
        end else begin
          wr_ctr = 2'b10;
        end
      end else if (upd_match) begin
        // Not-taken hit only weakens the counter; target is kept
        wr_en     = 1'b1;
        wr_target = target_mem[upd_idx];
        wr_ctr    = (ctr_mem[upd_idx] == 2'b00) ? 2'b00 : ctr_mem[upd_idx] - 2'b01;
      end else begin
        wr_en = 1'b0;
      end
    end else begin
      wr_en = 1'b0;
    end
  end

  // Table storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_mem[i]  <= 1'b0;
        tag_mem[i]    <= '0;
        target_mem[i] <= 32'd0;
        ctr_mem[i]    <= 2'b01;
      end
    end else if (wr_en) begin
      valid_mem[upd_idx]  <= wr_valid;
      tag_mem[upd_idx]    <= wr_tag;
      target_mem[upd_idx] <= wr_target;
      ctr_mem[upd_idx]    <= wr_ctr;
    end
  end

`ifdef BP_PERF_CNT_EN
  // Free-running event counters, wrap modulo 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bp_branch_cnt     <= 32'd0;
      bp_mispredict_cnt <= 32'd0;
    end else begin
      if (upd) begin
        bp_branch_cnt <= bp_branch_cnt + 32'd1;
      end
      if (EX_mispredict) begin
        bp_mispredict_cnt <= bp_mispredict_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (INDEX_W=4).
// Perf-counter checks are compiled in when BP_PERF_CNT_EN is defined.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IF_PC;
  logic        IF_hit;
  logic [31:0] IF_pred_PC;
  logic [31:0] ID_EX_PC;
  logic        ID_EX_Branch;
  logic        ID_EX_Jump;
  logic        ID_EX_hit;
  logic        PCSrc;
  logic [31:0] PC_Branch;
  logic        EX_mispredict;
`ifdef BP_PERF_CNT_EN
  logic [31:0] bp_branch_cnt;
  logic [31:0] bp_mispredict_cnt;
`endif

  int tests = 0;
  int fails = 0;

  branch_predictor #(.INDEX_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .IF_PC         (IF_PC),
    .IF_hit        (IF_hit),
    .IF_pred_PC    (IF_pred_PC),
    .ID_EX_PC      (ID_EX_PC),
    .ID_EX_Branch  (ID_EX_Branch),
    .ID_EX_Jump    (ID_EX_Jump),
    .ID_EX_hit     (ID_EX_hit),
    .PCSrc         (PCSrc),
    .PC_Branch     (PC_Branch),
    .EX_mispredict (EX_mispredict)
`ifdef BP_PERF_CNT_EN
    ,
    .bp_branch_cnt     (bp_branch_cnt),
    .bp_mispredict_cnt (bp_mispredict_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ex(input logic br, input logic jmp, input logic hit, input logic src,
                    input logic [31:0] pc, input logic [31:0] tgt);
    ID_EX_Branch = br;
    ID_EX_Jump   = jmp;
    ID_EX_hit    = hit;
    PCSrc        = src;
    ID_EX_PC     = pc;
    PC_Branch    = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic [31:0] pred);
    IF_PC = pc;
    #1;
    chk({tag, "_hit"}, {31'd0, IF_hit}, {31'd0, hit});
    chk({tag, "_pred"}, IF_pred_PC, pred);
  endtask

  initial begin
    reset = 1'b1;
    IF_PC = 32'h40;
    ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    reset = 1'b0;
    look("reset_lookup", 32'h40, 1'b0, 32'h44);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // first taken resolution at 0x40; same-cycle lookup sees old contents
    ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h100);
    look("collide_old", 32'h40, 1'b0, 32'h44);
    chk("mp_first_taken", {31'd0, EX_mispredict}, 32'd1);
    tick();
    ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    look("trained_ctr2", 32'h40, 1'b1, 32'h100);

    // three more taken -> ctr saturates at 3
    for (int i = 0; i < 3; i++) begin
      ex(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h100);
      #1;
      chk("mp_taken_correct", {31'd0, EX_mispredict}, 32'd0);
      tick();
    end
    ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    chk("mp_not_taken", {31'd0, EX_mispredict}, 32'd1);
    tick();
    look("nt1_ctr2", 32'h40, 1'b1, 32'h100);
    tick();
    look("nt2_ctr1", 32'h40, 1'b0, 32'h44);
    tick();
    ex(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
    #1;
    chk("mp_nt_correct", {31'd0, EX_mispredict}, 32'd0);
    tick();
    // ctr is now 0; two taken steps needed before predicting taken again
    ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h120);
    tick();
    look("ctr0_to_1", 32'h40, 1'b0, 32'h44);
    tick();
    ex(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    chk("mp_no_upd", {31'd0, EX_mispredict}, 32'd0);
    look("ctr1_to_2", 32'h40, 1'b1, 32'h120);

    // alias: 0x80 shares index 0 with 0x40
    ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h500);
    tick();
    ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    look("alias_evicted", 32'h40, 1'b0, 32'h44);
    look("alias_new", 32'h80, 1'b1, 32'h500);
    ex(1'b1, 1'b0, 1'b0, 1'b0, 32'hC0, 32'h0);
    tick();
    ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    look("nt_miss_nowrite", 32'h80, 1'b1, 32'h500);

    // async reset during a pending JAL write
    ex(1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h200);
    #2;
    reset = 1'b1;
    look("async_reset", 32'h80, 1'b0, 32'h84);
    tick();
    reset = 1'b0;
    ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    look("reset_discard", 32'h20, 1'b0, 32'h24);
`ifdef BP_PERF_CNT_EN
    chk("cnt_reset_br", bp_branch_cnt, 32'd0);
    chk("cnt_reset_mp", bp_mispredict_cnt, 32'd0);
`endif

    // JAL then target-mismatch re-resolve
    ex(1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h200);
    #1;
    chk("mp_jal_first", {31'd0, EX_mispredict}, 32'd1);
    tick();
    ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    look("jal_trained", 32'h20, 1'b1, 32'h200);
    ex(1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h300);
    #1;
    chk("mp_target", {31'd0, EX_mispredict}, 32'd1);
    tick();
    ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    look("jal_retarget", 32'h20, 1'b1, 32'h300);
`ifdef BP_PERF_CNT_EN
    chk("cnt_branch", bp_branch_cnt, 32'd2);
    chk("cnt_mispredict", bp_mispredict_cnt, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
